uba_intr_ack: RTL
=================

// Module: uba_intr_ack
//
// PURPOSE
//   Unibus interrupt-acknowledge ("who are you") sequencer for the UBA. It sits
//   beside the UBA interrupt-request encoder and consumes the same per-device
//   BR7..BR4 requests and the PIH/PIL level fields.
//   On a CPU acknowledge of a PI level, it decides whether this UBA owns that
//   level, arbitrates one device/BR winner and issues a one-hot grant. It then
//   waits for the device's vector and returns that vector (or a timeout) to the
//   bus interface.
//
// PARAMETERS
//   VECW     16   width of interrupt vector returned by devices/to bus
//   TIMEOUT  64   cycles to wait for devVECTV after grant before aborting (>=2)
//
// PORTS
//   clk       in   1         clock
//   rst       in   1         reset; asynchronous, active-low
//   ackREQ    in   1         one-cycle pulse: CPU acknowledging PI level ackPI
//   ackPI     in   3         PI level being acknowledged (1..7; 0 = none)
//   statPIH   in   3         PI level assigned to BR7/BR6 (from UBASR)
//   statPIL   in   3         PI level assigned to BR5/BR4 (from UBASR)
//   devINTR   in   4x[7:4]   per-device bus requests, devices 1..4
//   devACKO   out  4x[7:4]   one-hot grant to device/BR
//   devVECT   in   VECW      vector from granted device (shared bus)
//   devVECTV  in   1         devVECT valid, from granted device
//   ackBUSY   out  1         sequencer not IDLE
//   vectOUT   out  VECW      vector returned to bus interface
//   vectVALID out  1         one-cycle pulse: vectOUT valid
//   ackNONE   out  1         one-cycle pulse: level not ours, or no request
//   ackTMO    out  1         one-cycle pulse: granted device did not answer
//
// BEHAVIOUR
//   Reset: FSM=IDLE. devACKO=0, vectOUT=0, vectVALID=0, ackNONE=0, ackTMO=0,
//     ackBUSY=0, timer=0.
//   FSM states are IDLE, ARB, GRANT and DONE.
//   IDLE: when ackREQ=1, register ackPI and a snapshot of devINTR, then go to ARB.
//   ARB: takes one cycle.
//     Level match, in order:
//       - high group if ackPI!=0, ackPI==statPIH and any BR7/BR6 is set;
//       - otherwise low group if ackPI!=0, ackPI==statPIL and any BR5/BR4 is set.
//     When statPIH==statPIL, the high group always wins.
//     Priority within a group: BR7 before BR6 (BR5 before BR4), then device 1
//       before 2, 3, 4.
//     On a winner, set exactly one devACKO bit, set timer to TIMEOUT-1 and go
//       to GRANT.
//     With no match, pulse ackNONE and set vectOUT=0, then go to DONE.
//   GRANT: devACKO holds steady.
//     - devVECTV=1: latch devVECT into vectOUT, clear devACKO, go to DONE with
//       vectVALID=1.
//     - timer==0 and no devVECTV: clear devACKO, vectOUT=0, pulse ackTMO, go
//       to DONE.
//     - otherwise decrement timer. A device dropping its BR mid-GRANT does not
//       abort the cycle.
//   DONE: takes one cycle, all pulses clear, then return to IDLE.
//   Latency: ackREQ at cycle N, grant visible N+2. devVECTV at M gives
//     vectVALID at M+1. No-match case gives ackNONE at N+2.
//   ackREQ is ignored while ackBUSY=1 (any state but IDLE). No queuing.
//   devVECTV outside GRANT is ignored.
//   At most one of vectVALID/ackNONE/ackTMO per acknowledge, each exactly 1
//     cycle.
//   Async reset mid-cycle: grant drops immediately, no pulse is generated, and
//     the FSM returns to IDLE.
//
// TESTING
//   1. PIH=3, dev2 BR6; ackREQ with ackPI=3 -> devACKO[2][6]=1 at N+2. Then
//      devVECTV with 16'o254 -> vectVALID with vectOUT=16'o254, grant cleared.
//   2. dev3 BR7 and dev1 BR6, PIH=5; ackPI=5 -> grant dev3 BR7 only. Repeat with
//      dev1 BR7 and dev4 BR7 -> grant dev1.
//   3. PIH=PIL=2, dev1 BR4 and dev4 BR6; ackPI=2 -> grant dev4 BR6. Clear BR6,
//      ackPI=2 -> grant dev1 BR4.
//   4. PIL=4, no requests, ackPI=4 -> ackNONE at N+2, vectOUT=0. ackPI=0 with
//      requests present -> ackNONE.
//   5. TIMEOUT=64 with no devVECTV -> ackTMO exactly 64 cycles after the grant
//      asserts, devACKO=0.
//   6. Second ackREQ during GRANT -> ignored. rst low during GRANT -> devACKO=0
//      asynchronously, no pulses; next ackREQ is serviced normally.

Source files
------------

// File: rtl/uba_intr_ack.sv
// uba_intr_ack: Unibus interrupt-acknowledge ("who are you") sequencer.
// On a CPU acknowledge of a PI level, decide whether this UBA owns the level,
// pick one device/BR winner, drive a one-hot grant, then return the device
// vector (or a timeout) to the bus interface.
//
// Request/grant buses are flattened: bit index = (dev-1)*4 + (br-4),
// i.e. devINTR[3:0] is device 1 BR7..BR4 as [3]=BR7 .. [0]=BR4.
module uba_intr_ack #(
  parameter int VECW    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ackREQ,
  input  logic [2:0]      ackPI,
  input  logic [2:0]      statPIH,
  input  logic [2:0]      statPIL,
  input  logic [15:0]     devINTR,
  output logic [15:0]     devACKO,
  input  logic [VECW-1:0] devVECT,
  input  logic            devVECTV,
  output logic            ackBUSY,
  output logic [VECW-1:0] vectOUT,
  output logic            vectVALID,
  output logic            ackNONE,
  output logic            ackTMO
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      pi_q, pi_d;
  logic [15:0]     intr_q, intr_d;
  logic [15:0]     acko_q, acko_d;
  logic [VECW-1:0] vect_q, vect_d;
  logic            vv_q, vv_d;
  logic            none_q, none_d;
  logic            tmo_q, tmo_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            hi_any_s, lo_any_s;
  logic            hi_sel_s, lo_sel_s;
  logic [7:0]      cand_s, sel8_s;
  logic [15:0]     win_s;
  logic            win_found_s;

  // Arbitration: choose the owning group, then the first request in priority order.
  always_comb begin
    hi_any_s = |{intr_q[15:14], intr_q[11:10], intr_q[7:6], intr_q[3:2]};
    lo_any_s = |{intr_q[13:12], intr_q[9:8], intr_q[5:4], intr_q[1:0]};
    // The high group is checked first, so it wins whenever PIH==PIL.
    hi_sel_s = (pi_q != 3'd0) && (pi_q == statPIH) && hi_any_s;
    lo_sel_s = !hi_sel_s && (pi_q != 3'd0) && (pi_q == statPIL) && lo_any_s;
    // cand_s is in priority order: [3:0] upper BR dev1..4, [7:4] lower BR dev1..4.
    cand_s = 8'h00;
    for (int d = 0; d < 4; d++) begin
      if (hi_sel_s) begin
        cand_s[d]     = intr_q[d*4 + 3];
        cand_s[4 + d] = intr_q[d*4 + 2];
      end else if (lo_sel_s) begin
        cand_s[d]     = intr_q[d*4 + 1];
        cand_s[4 + d] = intr_q[d*4 + 0];
      end else begin
        cand_s[d]     = 1'b0;
        cand_s[4 + d] = 1'b0;
      end
    end
    // Isolate lowest set bit = highest-priority requester.
    sel8_s      = cand_s & (~cand_s + 8'd1);
    win_found_s = |sel8_s;
    win_s       = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      win_s[d*4 + 3] = hi_sel_s & sel8_s[d];
      win_s[d*4 + 2] = hi_sel_s & sel8_s[4 + d];
      win_s[d*4 + 1] = lo_sel_s & sel8_s[d];
      win_s[d*4 + 0] = lo_sel_s & sel8_s[4 + d];
    end
  end

  // Next-state logic for the acknowledge sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ackREQ) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        if (win_found_s) begin
          state_d = S_GRANT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_GRANT: begin
        if (devVECTV || (timer_q == {TW{1'b0}})) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; pulses default low so each lasts one cycle.
  always_comb begin
    pi_d    = pi_q;
    intr_d  = intr_q;
    acko_d  = acko_q;
    vect_d  = vect_q;
    timer_d = timer_q;
    vv_d    = 1'b0;
    none_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ackREQ) begin
          pi_d   = ackPI;
          intr_d = devINTR;
        end else begin
          pi_d   = pi_q;
          intr_d = intr_q;
        end
      end
      S_ARB: begin
        if (win_found_s) begin
          acko_d  = win_s;
          timer_d = TMO_LOAD;
        end else begin
          none_d = 1'b1;
          vect_d = {VECW{1'b0}};
        end
      end
      S_GRANT: begin
        // Requests are not re-examined here: a BR dropping mid-grant is harmless.
        if (devVECTV) begin
          vect_d = devVECT;
          vv_d   = 1'b1;
          acko_d = 16'h0000;
        end else if (timer_q == {TW{1'b0}}) begin
          acko_d = 16'h0000;
          vect_d = {VECW{1'b0}};
          tmo_d  = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DONE: begin
        acko_d = 16'h0000;
      end
      default: begin
        acko_d = 16'h0000;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pi_q    <= 3'd0;
      intr_q  <= 16'h0000;
      acko_q  <= 16'h0000;
      vect_q  <= {VECW{1'b0}};
      vv_q    <= 1'b0;
      none_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      timer_q <= {TW{1'b0}};
    end else begin
      pi_q    <= pi_d;
      intr_q  <= intr_d;
      acko_q  <= acko_d;
      vect_q  <= vect_d;
      vv_q    <= vv_d;
      none_q  <= none_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      timer_q <= timer_d;
    end
  end

  assign devACKO   = acko_q;
  assign vectOUT   = vect_q;
  assign vectVALID = vv_q;
  assign ackNONE   = none_q;
  assign ackTMO    = tmo_q;
  assign ackBUSY   = busy_q;

endmodule
